// File: rtl/branch_redirect_ctrl_if.sv
// Bundle between EX, the fetch unit and hazard logic for branch_redirect_ctrl.
// slave is the controller side; master is the EX/fetch side that drives it.
interface branch_redirect_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic              ex_valid;
  logic [2:0]        ex_branch_type;
  logic              ex_taken;
  logic              ex_pred_taken;
  logic [ADDR_W-1:0] ex_target;
  logic [ADDR_W-1:0] ex_pc_plus4;
  logic              fetch_ready;

  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              flush_if;
  logic              flush_id;
  logic              stall_ex;
  logic              busy;
  logic [CNT_W-1:0]  branch_cnt;
  logic [CNT_W-1:0]  mispred_cnt;

  modport master (
    output ex_valid, ex_branch_type, ex_taken, ex_pred_taken,
           ex_target, ex_pc_plus4, fetch_ready,
    input  redirect_valid, redirect_pc, flush_if, flush_id,
           stall_ex, busy, branch_cnt, mispred_cnt
  );

  modport slave (
    input  ex_valid, ex_branch_type, ex_taken, ex_pred_taken,
           ex_target, ex_pc_plus4, fetch_ready,
    output redirect_valid, redirect_pc, flush_if, flush_id,
           stall_ex, busy, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Mispredict recovery sequencer: offers a corrected PC to fetch, then flushes IF/ID.
// Define PERF_CNT_EN to build the saturating branch/mispredict performance counters.
module branch_redirect_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  branch_redirect_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    REDIRECT,
    FLUSH
  } state_t;

  localparam logic [3:0] FLUSH_INIT = (FLUSH_CYCLES > 0) ? 4'(FLUSH_CYCLES - 1) : 4'd0;

  state_t            state;
  logic [3:0]        flush_cnt;
  logic              redirect_valid_q;
  logic [ADDR_W-1:0] redirect_pc_q;
  logic              flush_if_q;
  logic              flush_id_q;
  logic              stall_ex_q;
  logic              busy_q;

  logic              is_br;
  logic              mispred;
  logic [ADDR_W-1:0] fix_pc;

  // Branch type 7 is reserved and behaves exactly like NONE.
  assign is_br   = bus.ex_valid && (bus.ex_branch_type != 3'd0) && (bus.ex_branch_type != 3'd7);
  assign mispred = is_br && (bus.ex_taken != bus.ex_pred_taken);
  assign fix_pc  = bus.ex_taken ? bus.ex_target : bus.ex_pc_plus4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      flush_cnt        <= 4'd0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_if_q       <= 1'b0;
      flush_id_q       <= 1'b0;
      stall_ex_q       <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mispred) begin
            state            <= REDIRECT;
            redirect_pc_q    <= fix_pc;
            redirect_valid_q <= 1'b1;
            flush_if_q       <= 1'b1;
            flush_id_q       <= 1'b1;
            stall_ex_q       <= 1'b1;
            busy_q           <= 1'b1;
          end
        end
        REDIRECT: begin
          // EX inputs are bubbles here; only the fetch handshake matters.
          if (redirect_valid_q && bus.fetch_ready) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            stall_ex_q       <= 1'b0;
            if (FLUSH_CYCLES == 0) begin
              state      <= IDLE;
              flush_if_q <= 1'b0;
              flush_id_q <= 1'b0;
              busy_q     <= 1'b0;
            end else begin
              state     <= FLUSH;
              flush_cnt <= FLUSH_INIT;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == 4'd0) begin
            state      <= IDLE;
            flush_if_q <= 1'b0;
            flush_id_q <= 1'b0;
            busy_q     <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        default: begin
          state            <= IDLE;
          flush_cnt        <= 4'd0;
          redirect_valid_q <= 1'b0;
          redirect_pc_q    <= '0;
          flush_if_q       <= 1'b0;
          flush_id_q       <= 1'b0;
          stall_ex_q       <= 1'b0;
          busy_q           <= 1'b0;
        end
      endcase
    end
  end

  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush_if       = flush_if_q;
  assign bus.flush_id       = flush_id_q;
  assign bus.stall_ex       = stall_ex_q;
  assign bus.busy           = busy_q;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] branch_q;
  logic [CNT_W-1:0] mispred_q;

  // Only IDLE samples count; squashed bubbles in REDIRECT/FLUSH are not real branches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_q  <= '0;
      mispred_q <= '0;
    end else if (state == IDLE) begin
      if (is_br && (branch_q != '1)) begin
        branch_q <= branch_q + CNT_W'(1);
      end
      if (mispred && (mispred_q != '1)) begin
        mispred_q <= mispred_q + CNT_W'(1);
      end
    end
  end

  assign bus.branch_cnt  = branch_q;
  assign bus.mispred_cnt = mispred_q;
`else
  assign bus.branch_cnt  = '0;
  assign bus.mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scenario bench for branch_redirect_ctrl: a FLUSH_CYCLES=2 instance and a FLUSH_CYCLES=0 instance.
// Expected corrected PCs are queued when a mispredict is driven and retired on the fetch handshake.
module tb_branch_redirect_ctrl;

`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic reset;

  branch_redirect_ctrl_if #(.ADDR_W(32), .CNT_W(16)) bus  ();
  branch_redirect_ctrl_if #(.ADDR_W(32), .CNT_W(16)) bus0 ();

  branch_redirect_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  branch_redirect_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(0), .CNT_W(16)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  int checks = 0;
  int fails  = 0;

  logic [31:0] pc_q[$];
  logic [31:0] pc0_q[$];
  logic [15:0] exp_br, exp_mp, exp0_br, exp0_mp;
  logic [31:0] exp_pc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input bit v, input logic [2:0] t, input bit tk, input bit pr,
                               input logic [31:0] tgt, input logic [31:0] pc4);
    bus.ex_valid       = v;
    bus.ex_branch_type = t;
    bus.ex_taken       = tk;
    bus.ex_pred_taken  = pr;
    bus.ex_target      = tgt;
    bus.ex_pc_plus4    = pc4;
  endtask

  task automatic clear_ex();
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.redirect_valid, bus.flush_if, bus.flush_id, bus.stall_ex, bus.busy} !== 5'b00000) begin
      fails++;
      $display("[TB] FAIL reset_ctrl: got %b expected 00000",
               {bus.redirect_valid, bus.flush_if, bus.flush_id, bus.stall_ex, bus.busy});
    end
    checks++;
    if (bus.redirect_pc !== 32'h0) begin
      fails++;
      $display("[TB] FAIL reset_pc: got %h expected 00000000", bus.redirect_pc);
    end
    checks++;
    if ({bus.branch_cnt, bus.mispred_cnt} !== 32'h0) begin
      fails++;
      $display("[TB] FAIL reset_cnt: got %h/%h expected 0/0", bus.branch_cnt, bus.mispred_cnt);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.redirect_valid, bus.flush_if, bus.flush_id, bus.stall_ex, bus.busy} !== 5'b00000) begin
      fails++;
      $display("[TB] FAIL reset_release: got %b expected 00000",
               {bus.redirect_valid, bus.flush_if, bus.flush_id, bus.stall_ex, bus.busy});
    end
  endtask

  task automatic test_predicted_correct();
    applyStimulus(1'b1, 3'd1, 1'b1, 1'b1, 32'h0000_0400, 32'h0000_0024);
    exp_br++;
    @(negedge clk);
    clear_ex();
    checks++;
    if ({bus.redirect_valid, bus.flush_if, bus.flush_id, bus.stall_ex, bus.busy} !== 5'b00000) begin
      fails++;
      $display("[TB] FAIL correct_pred_ctrl: got %b expected 00000",
               {bus.redirect_valid, bus.flush_if, bus.flush_id, bus.stall_ex, bus.busy});
    end
    checks++;
    if ({bus.branch_cnt, bus.mispred_cnt} !== (PERF ? {exp_br, exp_mp} : 32'h0)) begin
      fails++;
      $display("[TB] FAIL correct_pred_cnt: got %h/%h expected %h/%h", bus.branch_cnt,
               bus.mispred_cnt, PERF ? exp_br : 16'h0, PERF ? exp_mp : 16'h0);
    end
  endtask

  task automatic test_mispredict_taken();
    bus.fetch_ready = 1'b1;
    applyStimulus(1'b1, 3'd2, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0054);
    pc_q.push_back(32'h0000_0100);
    exp_br++;
    exp_mp++;
    @(negedge clk);
    clear_ex();
    checks++;
    if ({bus.redirect_valid, bus.flush_if, bus.flush_id, bus.stall_ex, bus.busy} !== 5'b11111) begin
      fails++;
      $display("[TB] FAIL taken_redirect_ctrl: got %b expected 11111",
               {bus.redirect_valid, bus.flush_if, bus.flush_id, bus.stall_ex, bus.busy});
    end
    exp_pc = (pc_q.size() != 0) ? pc_q[0] : 32'hxxxx_xxxx;
    checks++;
    if (bus.redirect_pc !== exp_pc) begin
      fails++;
      $display("[TB] FAIL taken_redirect_pc: got %h expected %h", bus.redirect_pc, exp_pc);
    end
    if (bus.redirect_valid && bus.fetch_ready && pc_q.size() != 0) void'(pc_q.pop_front());
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.redirect_valid, bus.flush_if, bus.flush_id, bus.stall_ex, bus.busy} !== 5'b01101) begin
        fails++;
        $display("[TB] FAIL taken_flush_%0d: got %b expected 01101", i,
                 {bus.redirect_valid, bus.flush_if, bus.flush_id, bus.stall_ex, bus.busy});
      end
    end
    @(negedge clk);
    checks++;
    if ({bus.redirect_valid, bus.flush_if, bus.flush_id, bus.stall_ex, bus.busy} !== 5'b00000) begin
      fails++;
      $display("[TB] FAIL taken_idle: got %b expected 00000",
               {bus.redirect_valid, bus.flush_if, bus.flush_id, bus.stall_ex, bus.busy});
    end
    checks++;
    if ({bus.branch_cnt, bus.mispred_cnt} !== (PERF ? {exp_br, exp_mp} : 32'h0)) begin
      fails++;
      $display("[TB] FAIL taken_cnt: got %h/%h expected %h/%h", bus.branch_cnt,
               bus.mispred_cnt, PERF ? exp_br : 16'h0, PERF ? exp_mp : 16'h0);
    end
  endtask

  task automatic test_backpressure();
    bus.fetch_ready = 1'b0;
    applyStimulus(1'b1, 3'd3, 1'b0, 1'b1, 32'h0000_0200, 32'h0000_0048);
    pc_q.push_back(32'h0000_0048);
    exp_br++;
    exp_mp++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      clear_ex();
      checks++;
      if ({bus.redirect_valid, bus.flush_if, bus.flush_id, bus.stall_ex, bus.busy} !== 5'b11111) begin
        fails++;
        $display("[TB] FAIL bp_hold_ctrl_%0d: got %b expected 11111", i,
                 {bus.redirect_valid, bus.flush_if, bus.flush_id, bus.stall_ex, bus.busy});
      end
      exp_pc = (pc_q.size() != 0) ? pc_q[0] : 32'hxxxx_xxxx;
      checks++;
      if (bus.redirect_pc !== exp_pc) begin
        fails++;
        $display("[TB] FAIL bp_hold_pc_%0d: got %h expected %h", i, bus.redirect_pc, exp_pc);
      end
      if (i == 3) bus.fetch_ready = 1'b1;
      if (bus.redirect_valid && bus.fetch_ready && pc_q.size() != 0) void'(pc_q.pop_front());
    end
    @(negedge clk);
    checks++;
    if ({bus.redirect_valid, bus.flush_if, bus.flush_id, bus.stall_ex, bus.busy} !== 5'b01101) begin
      fails++;
      $display("[TB] FAIL bp_release_flush: got %b expected 01101",
               {bus.redirect_valid, bus.flush_if, bus.flush_id, bus.stall_ex, bus.busy});
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.redirect_valid, bus.flush_if, bus.flush_id, bus.stall_ex, bus.busy} !== 5'b00000) begin
      fails++;
      $display("[TB] FAIL bp_idle: got %b expected 00000",
               {bus.redirect_valid, bus.flush_if, bus.flush_id, bus.stall_ex, bus.busy});
    end
  endtask

  task automatic test_ignored_inputs();
    bus.fetch_ready = 1'b1;
    applyStimulus(1'b1, 3'd1, 1'b1, 1'b0, 32'h0000_2000, 32'h0000_1004);
    pc_q.push_back(32'h0000_2000);
    exp_br++;
    exp_mp++;
    @(negedge clk);
    checks++;
    exp_pc = (pc_q.size() != 0) ? pc_q[0] : 32'hxxxx_xxxx;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== exp_pc) begin
      fails++;
      $display("[TB] FAIL ign_redirect: got valid=%b pc=%h expected valid=1 pc=%h",
               bus.redirect_valid, bus.redirect_pc, exp_pc);
    end
    if (bus.redirect_valid && bus.fetch_ready && pc_q.size() != 0) void'(pc_q.pop_front());
    applyStimulus(1'b1, 3'd4, 1'b0, 1'b1, 32'h0000_5000, 32'h0000_3004);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.redirect_valid, bus.flush_if, bus.flush_id, bus.stall_ex, bus.busy} !== 5'b01101) begin
        fails++;
        $display("[TB] FAIL ign_flush_%0d: got %b expected 01101", i,
                 {bus.redirect_valid, bus.flush_if, bus.flush_id, bus.stall_ex, bus.busy});
      end
    end
    clear_ex();
    @(negedge clk);
    checks++;
    if ({bus.redirect_valid, bus.flush_if, bus.flush_id, bus.stall_ex, bus.busy} !== 5'b00000) begin
      fails++;
      $display("[TB] FAIL ign_idle: got %b expected 00000",
               {bus.redirect_valid, bus.flush_if, bus.flush_id, bus.stall_ex, bus.busy});
    end
    checks++;
    if ({bus.branch_cnt, bus.mispred_cnt} !== (PERF ? {exp_br, exp_mp} : 32'h0)) begin
      fails++;
      $display("[TB] FAIL ign_cnt: got %h/%h expected %h/%h", bus.branch_cnt,
               bus.mispred_cnt, PERF ? exp_br : 16'h0, PERF ? exp_mp : 16'h0);
    end
  endtask

  task automatic test_reset_mid_redirect();
    bus.fetch_ready = 1'b0;
    applyStimulus(1'b1, 3'd5, 1'b1, 1'b0, 32'h7777_0000, 32'h0000_0abc);
    pc_q.push_back(32'h7777_0000);
    exp_br++;
    exp_mp++;
    @(negedge clk);
    clear_ex();
    checks++;
    if ({bus.redirect_valid, bus.flush_if, bus.flush_id, bus.stall_ex, bus.busy} !== 5'b11111) begin
      fails++;
      $display("[TB] FAIL rst_mid_pre: got %b expected 11111",
               {bus.redirect_valid, bus.flush_if, bus.flush_id, bus.stall_ex, bus.busy});
    end
    #2;
    reset = 1'b1;
    #1;
    pc_q.delete();
    exp_br = '0;
    exp_mp = '0;
    checks++;
    if ({bus.redirect_valid, bus.flush_if, bus.flush_id, bus.stall_ex, bus.busy} !== 5'b00000) begin
      fails++;
      $display("[TB] FAIL rst_mid_ctrl: got %b expected 00000",
               {bus.redirect_valid, bus.flush_if, bus.flush_id, bus.stall_ex, bus.busy});
    end
    checks++;
    if ({bus.redirect_pc, bus.branch_cnt, bus.mispred_cnt} !== 64'h0) begin
      fails++;
      $display("[TB] FAIL rst_mid_data: got pc=%h cnt=%h/%h expected all zero",
               bus.redirect_pc, bus.branch_cnt, bus.mispred_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    bus.fetch_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.redirect_valid, bus.flush_if, bus.flush_id, bus.stall_ex, bus.busy} !== 5'b00000) begin
      fails++;
      $display("[TB] FAIL rst_mid_after: got %b expected 00000",
               {bus.redirect_valid, bus.flush_if, bus.flush_id, bus.stall_ex, bus.busy});
    end
  endtask

  task automatic test_zero_flush();
    bus0.fetch_ready    = 1'b1;
    bus0.ex_valid       = 1'b1;
    bus0.ex_branch_type = 3'd7;
    bus0.ex_taken       = 1'b1;
    bus0.ex_pred_taken  = 1'b0;
    bus0.ex_target      = 32'h0000_0800;
    bus0.ex_pc_plus4    = 32'h0000_0010;
    @(negedge clk);
    checks++;
    if ({bus0.redirect_valid, bus0.flush_if, bus0.flush_id, bus0.stall_ex, bus0.busy} !== 5'b00000) begin
      fails++;
      $display("[TB] FAIL zf_type7: got %b expected 00000",
               {bus0.redirect_valid, bus0.flush_if, bus0.flush_id, bus0.stall_ex, bus0.busy});
    end
    bus0.ex_branch_type = 3'd6;
    bus0.ex_target      = 32'hDEAD_BEEF;
    pc0_q.push_back(32'hDEAD_BEEF);
    exp0_br++;
    exp0_mp++;
    @(negedge clk);
    bus0.ex_valid = 1'b0;
    checks++;
    if ({bus0.redirect_valid, bus0.flush_if, bus0.flush_id, bus0.stall_ex, bus0.busy} !== 5'b11111) begin
      fails++;
      $display("[TB] FAIL zf_redirect_ctrl: got %b expected 11111",
               {bus0.redirect_valid, bus0.flush_if, bus0.flush_id, bus0.stall_ex, bus0.busy});
    end
    exp_pc = (pc0_q.size() != 0) ? pc0_q[0] : 32'hxxxx_xxxx;
    checks++;
    if (bus0.redirect_pc !== exp_pc) begin
      fails++;
      $display("[TB] FAIL zf_redirect_pc: got %h expected %h", bus0.redirect_pc, exp_pc);
    end
    if (bus0.redirect_valid && bus0.fetch_ready && pc0_q.size() != 0) void'(pc0_q.pop_front());
    @(negedge clk);
    checks++;
    if ({bus0.redirect_valid, bus0.flush_if, bus0.flush_id, bus0.stall_ex, bus0.busy,
         bus0.redirect_pc} !== {5'b00000, 32'h0}) begin
      fails++;
      $display("[TB] FAIL zf_idle: got %b pc=%h expected 00000 pc=00000000",
               {bus0.redirect_valid, bus0.flush_if, bus0.flush_id, bus0.stall_ex, bus0.busy},
               bus0.redirect_pc);
    end
    checks++;
    if ({bus0.branch_cnt, bus0.mispred_cnt} !== (PERF ? {exp0_br, exp0_mp} : 32'h0)) begin
      fails++;
      $display("[TB] FAIL zf_cnt: got %h/%h expected %h/%h", bus0.branch_cnt,
               bus0.mispred_cnt, PERF ? exp0_br : 16'h0, PERF ? exp0_mp : 16'h0);
    end
    checks++;
    if (pc_q.size() + pc0_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", pc_q.size() + pc0_q.size());
    end
  endtask

  initial begin
    reset   = 1'b1;
    exp_br  = '0;
    exp_mp  = '0;
    exp0_br = '0;
    exp0_mp = '0;
    clear_ex();
    bus.fetch_ready     = 1'b1;
    bus0.ex_valid       = 1'b0;
    bus0.ex_branch_type = 3'd0;
    bus0.ex_taken       = 1'b0;
    bus0.ex_pred_taken  = 1'b0;
    bus0.ex_target      = 32'h0;
    bus0.ex_pc_plus4    = 32'h0;
    bus0.fetch_ready    = 1'b0;

    test_reset();
    test_predicted_correct();
    test_mispredict_taken();
    test_backpressure();
    test_ignored_inputs();
    test_reset_mid_redirect();
    test_zero_flush();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
